// File: rtl/xor_stream_loader.sv
// Serial transmitter for the cipher core's load interface: a parallel key and
// message go out MSB first, framed by the load_key / load_msg strobes.
module xor_stream_loader #(
    parameter int KEY_SIZE = 32,
    parameter int MSG_SIZE = 512
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic [KEY_SIZE-1:0] iKey,
    input  logic [MSG_SIZE-1:0] iMessage,
    input  logic                iStart,
    output logic                oReady,
    output logic                oSerial_data,
    output logic                oLoad_key,
    output logic                oLoad_msg,
    output logic                oDone
);
    // state  | meaning
    // S_IDLE | waiting for an accepted start, oReady high
    // S_KEY  | shifting out KEY_SIZE key bits
    // S_GAP  | one quiet cycle between key and message frames
    // S_MSG  | shifting out MSG_SIZE message bits
    // S_DONE | one cycle that produces the oDone pulse

    localparam int MAX_SIZE = (KEY_SIZE > MSG_SIZE) ? KEY_SIZE : MSG_SIZE;
    localparam int CNT_W    = $clog2(MAX_SIZE) + 1;

    typedef enum logic [2:0] {S_IDLE, S_KEY, S_GAP, S_MSG, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [KEY_SIZE-1:0] key_sr_q, key_sr_d;
    logic [MSG_SIZE-1:0] msg_sr_q, msg_sr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ready_q, ready_d;
    logic                serial_q, serial_d;
    logic                load_key_q, load_key_d;
    logic                load_msg_q, load_msg_d;
    logic                done_q, done_d;

    always_comb begin
        state_d    = state_q;
        key_sr_d   = key_sr_q;
        msg_sr_d   = msg_sr_q;
        cnt_d      = cnt_q;
        ready_d    = ready_q;
        serial_d   = serial_q;
        load_key_d = load_key_q;
        load_msg_d = load_msg_q;
        done_d     = done_q;

        if (ena) begin
            case (state_q)
                S_IDLE: begin
                    if (iStart) begin
                        key_sr_d = iKey;
                        msg_sr_d = iMessage;
                        cnt_d    = '0;
                        state_d  = S_KEY;
                    end
                end
                S_KEY: begin
                    key_sr_d = {key_sr_q[KEY_SIZE-2:0], 1'b0};
                    if (cnt_q == CNT_W'(KEY_SIZE - 1)) begin
                        cnt_d   = '0;
                        state_d = S_GAP;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_GAP: begin
                    cnt_d   = '0;
                    state_d = S_MSG;
                end
                S_MSG: begin
                    msg_sr_d = {msg_sr_q[MSG_SIZE-2:0], 1'b0};
                    if (cnt_q == CNT_W'(MSG_SIZE - 1)) begin
                        cnt_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase

            // Stream outputs reflect the state being left, so the first key bit
            // lands one cycle after the accepting edge; oReady tracks the new state.
            ready_d    = (state_d == S_IDLE);
            load_key_d = (state_q == S_KEY);
            load_msg_d = (state_q == S_MSG);
            done_d     = (state_q == S_DONE);
            serial_d   = ((state_q == S_KEY) && key_sr_q[KEY_SIZE-1]) ||
                         ((state_q == S_MSG) && msg_sr_q[MSG_SIZE-1]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            key_sr_q   <= '0;
            msg_sr_q   <= '0;
            cnt_q      <= '0;
            ready_q    <= 1'b1;
            serial_q   <= 1'b0;
            load_key_q <= 1'b0;
            load_msg_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            key_sr_q   <= key_sr_d;
            msg_sr_q   <= msg_sr_d;
            cnt_q      <= cnt_d;
            ready_q    <= ready_d;
            serial_q   <= serial_d;
            load_key_q <= load_key_d;
            load_msg_q <= load_msg_d;
            done_q     <= done_d;
        end
    end

    assign oReady       = ready_q;
    assign oSerial_data = serial_q;
    assign oLoad_key    = load_key_q;
    assign oLoad_msg    = load_msg_q;
    assign oDone        = done_q;

endmodule

// File: tb/tb_xor_stream_loader.sv
// Bench for xor_stream_loader: a default-size and a small instance, both checked
// every cycle against a frame-queue model of the serial stream.
module tb_xor_stream_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // instance a: 32-bit key, 512-bit message
    logic         rst_a, ena_a, start_a;
    logic [31:0]  key_a;
    logic [511:0] msg_a;
    logic         rdy_a, ser_a, lk_a, lm_a, done_a;

    // instance b: 8-bit key, 16-bit message
    logic         rst_b, ena_b, start_b;
    logic [7:0]   key_b;
    logic [15:0]  msg_b;
    logic         rdy_b, ser_b, lk_b, lm_b, done_b;

    xor_stream_loader u_dut_a (
        .clk(clk), .rst_n(rst_a), .ena(ena_a), .iKey(key_a), .iMessage(msg_a),
        .iStart(start_a), .oReady(rdy_a), .oSerial_data(ser_a), .oLoad_key(lk_a),
        .oLoad_msg(lm_a), .oDone(done_a));

    xor_stream_loader #(.KEY_SIZE(8), .MSG_SIZE(16)) u_dut_b (
        .clk(clk), .rst_n(rst_b), .ena(ena_b), .iKey(key_b), .iMessage(msg_b),
        .iStart(start_b), .oReady(rdy_b), .oSerial_data(ser_b), .oLoad_key(lk_b),
        .oLoad_msg(lm_b), .oDone(done_b));

    int checks = 0;
    int errors = 0;

    // Each entry is one enabled output cycle: {done, load_key, load_msg, data}.
    typedef logic [3:0] frame_t[$];
    frame_t     qa, qb;
    logic [3:0] exp_a = 4'h0, exp_b = 4'h0;
    bit         acc_b;

    function automatic frame_t build_frame(logic [511:0] key, int ks,
                                           logic [511:0] msg, int ms);
        frame_t f;
        for (int i = ks - 1; i >= 0; i--) f.push_back({3'b010, key[i]});
        f.push_back(4'b0000);
        for (int i = ms - 1; i >= 0; i--) f.push_back({3'b001, msg[i]});
        f.push_back(4'b1000);
        return f;
    endfunction

    task automatic cmp(string tag, int obs, int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one edge using the inputs as they stand, then clock
    // both DUTs and compare every output.
    task automatic tick();
        bit acc;
        if (!rst_a) begin
            qa.delete();
            exp_a = 4'h0;
        end else if (ena_a) begin
            acc = start_a && (qa.size() == 0);
            exp_a = 4'h0;
            if (qa.size() != 0) exp_a = qa.pop_front();
            if (acc) qa = build_frame({480'b0, key_a}, 32, msg_a, 512);
        end
        acc_b = 1'b0;
        if (!rst_b) begin
            qb.delete();
            exp_b = 4'h0;
        end else if (ena_b) begin
            acc = start_b && (qb.size() == 0);
            exp_b = 4'h0;
            if (qb.size() != 0) exp_b = qb.pop_front();
            if (acc) qb = build_frame({504'b0, key_b}, 8, {496'b0, msg_b}, 16);
            acc_b = acc;
        end
        @(posedge clk);
        #1;
        cmp("out_a", int'({done_a, lk_a, lm_a, ser_a}), int'(exp_a));
        cmp("ready_a", int'(rdy_a), int'(qa.size() == 0));
        cmp("out_b", int'({done_b, lk_b, lm_b, ser_b}), int'(exp_b));
        cmp("ready_b", int'(rdy_b), int'(qb.size() == 0));
    endtask

    task automatic start_frame_b(input logic [7:0] k, input logic [15:0] m);
        key_b   = k;
        msg_b   = m;
        ena_b   = 1'b1;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
    endtask

    // Run instance b until oDone (bounded), capturing the stream on enabled edges.
    task automatic run_b(input bit rand_ena, input bit inject,
                         output logic [7:0] ck, output logic [15:0] cm,
                         output int lkn, output int lmn, output int dn);
        ck = '0; cm = '0; lkn = 0; lmn = 0; dn = 0;
        for (int i = 0; i < 400; i++) begin
            ena_b = rand_ena ? 1'($urandom_range(0, 1)) : 1'b1;
            if (inject && lmn == 4) begin
                start_b = 1'b1;
                key_b   = 8'hFF;
                msg_b   = 16'hFFFF;
            end
            if (inject && lmn == 7) start_b = 1'b0;
            tick();
            if (ena_b) begin
                if (lk_b) begin ck = {ck[6:0], ser_b};  lkn++; end
                if (lm_b) begin cm = {cm[14:0], ser_b}; lmn++; end
                if (done_b) begin dn++; break; end
            end
        end
        ena_b   = 1'b1;
        start_b = 1'b0;
    endtask

    initial begin
        logic [31:0]  cap_key_a;
        logic [511:0] cap_msg_a;
        logic [7:0]   ck, kr;
        logic [15:0]  cm, mr;
        int           lkn, lmn, dn, done_at, last_lm, gap, lk_rise;
        logic         lk_prev;

        rst_a = 1'b0; ena_a = 1'b1; start_a = 1'b0; key_a = '0; msg_a = '0;
        rst_b = 1'b0; ena_b = 1'b1; start_b = 1'b0; key_b = '0; msg_b = '0;
        tick();
        tick();
        cmp("reset_ready_a", int'(rdy_a), 1);
        cmp("reset_outs_b", int'({done_b, lk_b, lm_b, ser_b}), 0);
        rst_a = 1'b1;
        rst_b = 1'b1;
        tick();

        // Default-size frame with a one-cycle start.
        key_a = 32'hA5A5_0F0F;
        msg_a = 512'h1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        cap_key_a = '0; cap_msg_a = '0; lkn = 0; lmn = 0; dn = 0; done_at = -1;
        for (int n = 1; n <= 600; n++) begin
            tick();
            if (lk_a) begin cap_key_a = {cap_key_a[30:0], ser_a}; lkn++; end
            if (lm_a) begin cap_msg_a = {cap_msg_a[510:0], ser_a}; lmn++; end
            if (done_a) begin dn++; if (done_at < 0) done_at = n; end
            if (n > 550) break;
        end
        cmp("a_key_cycles", lkn, 32);
        cmp("a_key_bits", int'(cap_key_a), int'(32'hA5A5_0F0F));
        cmp("a_msg_cycles", lmn, 512);
        cmp("a_msg_bits", int'(cap_msg_a === 512'h1), 1);
        cmp("a_done_latency", done_at, 546);
        cmp("a_done_count", dn, 1);

        // Small frame with ena toggled pseudo-randomly.
        start_frame_b(8'hC3, 16'hBEEF);
        run_b(1'b1, 1'b0, ck, cm, lkn, lmn, dn);
        cmp("b_ena_key", int'(ck), int'(8'hC3));
        cmp("b_ena_msg", int'(cm), int'(16'hBEEF));
        cmp("b_ena_key_len", lkn, 8);
        cmp("b_ena_msg_len", lmn, 16);
        cmp("b_ena_done", dn, 1);
        tick();

        // A start during MSG with different data is ignored.
        start_frame_b(8'h5A, 16'h1234);
        run_b(1'b0, 1'b1, ck, cm, lkn, lmn, dn);
        cmp("b_mid_key", int'(ck), int'(8'h5A));
        cmp("b_mid_msg", int'(cm), int'(16'h1234));
        cmp("b_mid_done", dn, 1);
        for (int i = 0; i < 4; i++) tick();
        cmp("b_mid_no_restart", int'(lk_b), 0);

        // iStart held high: two frames, the second capturing the new key.
        key_b = 8'h01; msg_b = 16'h0F0F; start_b = 1'b1;
        dn = 0; last_lm = -1; gap = -1; lk_rise = 0; lk_prev = 1'b0;
        for (int t = 0; t < 80; t++) begin
            tick();
            if (acc_b) key_b = 8'h80;
            if (lk_b && !lk_prev) begin
                lk_rise++;
                if (last_lm >= 0 && gap < 0) gap = t - last_lm;
            end
            lk_prev = lk_b;
            if (lm_b) last_lm = t;
            if (done_b) dn++;
            if (dn == 2) break;
        end
        start_b = 1'b0;
        cmp("b_held_frames", lk_rise, 2);
        cmp("b_held_done", dn, 2);
        cmp("b_held_gap", gap, 3);
        tick();

        // Reset at key bit 5, then a fresh frame.
        start_frame_b(8'h3C, 16'hA55A);
        lkn = 0;
        for (int i = 0; i < 20 && lkn < 5; i++) begin
            tick();
            if (lk_b) lkn++;
        end
        rst_b = 1'b0;
        tick();
        cmp("b_rst_outs", int'({done_b, lk_b, lm_b, ser_b}), 0);
        cmp("b_rst_ready", int'(rdy_b), 1);
        rst_b = 1'b1;
        tick();
        start_frame_b(8'h96, 16'h6C39);
        run_b(1'b0, 1'b0, ck, cm, lkn, lmn, dn);
        cmp("b_post_rst_key", int'(ck), int'(8'h96));
        cmp("b_post_rst_msg", int'(cm), int'(16'h6C39));
        cmp("b_post_rst_done", dn, 1);

        // Random frames with random ena.
        for (int r = 0; r < 4; r++) begin
            kr = 8'($urandom);
            mr = 16'($urandom);
            tick();
            start_frame_b(kr, mr);
            run_b(1'b1, 1'b0, ck, cm, lkn, lmn, dn);
            cmp("b_rand_key", int'(ck), int'(kr));
            cmp("b_rand_msg", int'(cm), int'(mr));
            cmp("b_rand_done", dn, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
